// File: rtl/mips_mem_arb_pkg.sv
// mips_mem_arb_pkg: shared state encoding and bus constants for the MIPS memory arbiter.
package mips_mem_arb_pkg;
    localparam int DATA_W = 32;
    localparam logic [3:0] BYTE_EN = 4'hF;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    typedef enum logic [2:0] {IDLE, FETCH, DATA, COMMIT, HALT, ERROR} state_t;
endpackage

// File: rtl/mips_mem_arb_watchdog.sv
// mips_mem_arb_watchdog: counts consecutive stalled cycles of one memory access and flags a timeout.
module mips_mem_arb_watchdog #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic stall,
    output logic timeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] count;
    // Any cycle without a stalled access restarts the count, so every access starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else count <= (busy && stall) ? ((count == CW'(MAX_WAIT)) ? count : count + 1'b1) : '0;
    end
    assign timeout = busy && stall && (count >= CW'(MAX_WAIT - 1));
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: sequences instruction fetch and data access of a MIPS core onto one memory bus.
// Optional one-entry fetch buffer enabled by defining MEM_ARB_FETCH_BUF_EN.
module mips_mem_arbiter #(
    parameter int DATA_W   = mips_mem_arb_pkg::DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    output logic              clk_enable,
    input  logic [31:0]       instr_address,
    output logic [DATA_W-1:0] instr_readdata,
    input  logic [31:0]       data_address,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [DATA_W-1:0] data_writedata,
    output logic [DATA_W-1:0] data_readdata,
    output logic [31:0]       mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              bus_error
);
    import mips_mem_arb_pkg::*;

    state_t state;
    logic fetch_ok, data_ok, hit, fetch_req, rd_req, wr_req, busy, timeout, bad_data;
    logic [DATA_W-1:0] fetch_data;

    assign fetch_ok  = instr_address[1:0] == 2'b00;
    assign data_ok   = data_address[1:0] == 2'b00;
    assign bad_data  = (data_read && data_write) || ((data_read || data_write) && !data_ok);
    // Requests are suppressed for illegal accesses so a faulting cycle never reaches memory.
    assign fetch_req = state == FETCH && fetch_ok && !hit;
    assign rd_req    = state == DATA && data_read && !data_write && data_ok;
    assign wr_req    = state == DATA && data_write && !data_read && data_ok;
    assign busy      = fetch_req || rd_req || wr_req;

    assign mem_read       = fetch_req || rd_req;
    assign mem_write      = wr_req;
    assign mem_address    = fetch_req ? {instr_address[31:2], 2'b00} :
                            (rd_req || wr_req) ? {data_address[31:2], 2'b00} : 32'h0;
    assign mem_writedata  = wr_req ? data_writedata : '0;
    assign mem_byteenable = busy ? BYTE_EN : 4'h0;

    mips_mem_arb_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .busy   (busy),
        .stall  (mem_waitrequest),
        .timeout(timeout)
    );

`ifdef MEM_ARB_FETCH_BUF_EN
    logic              buf_valid;
    logic [29:0]       buf_tag;
    logic [DATA_W-1:0] buf_data;
    assign hit        = state == FETCH && fetch_ok && buf_valid && buf_tag == instr_address[31:2];
    assign fetch_data = hit ? buf_data : mem_readdata;
    // A store to the buffered word makes the cached instruction stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (fetch_req && !mem_waitrequest) begin
            buf_valid <= 1'b1;
            buf_tag   <= instr_address[31:2];
            buf_data  <= mem_readdata;
        end else if (wr_req && buf_tag == data_address[31:2]) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign hit        = 1'b0;
    assign fetch_data = mem_readdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            clk_enable     <= 1'b0;
            bus_error      <= 1'b0;
            instr_readdata <= '0;
            data_readdata  <= '0;
        end else begin
            clk_enable <= 1'b0;
            case (state)
                IDLE: if (active) state <= FETCH;
                FETCH: begin
                    if (!fetch_ok || timeout) begin
                        state     <= ERROR;
                        bus_error <= 1'b1;
                    end else if (hit || !mem_waitrequest) begin
                        instr_readdata <= fetch_data;
                        state          <= DATA;
                    end
                end
                DATA: begin
                    if (bad_data || timeout) begin
                        state     <= ERROR;
                        bus_error <= 1'b1;
                    end else if (!busy || !mem_waitrequest) begin
                        if (rd_req) data_readdata <= mem_readdata;
                        state      <= COMMIT;
                        clk_enable <= 1'b1;
                    end
                end
                COMMIT: state <= active ? FETCH : HALT;
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed self-checking bench for mips_mem_arbiter.
module tb_mips_mem_arbiter;
    import mips_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset, active, clk_enable;
    logic [31:0] instr_address, instr_readdata, data_address, data_writedata, data_readdata;
    logic        data_read, data_write;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest, bus_error;
    logic [3:0]  mem_byteenable;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdata   (mem_readdata),
        .bus_error      (bus_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        active = 1'b0;
        data_read = 1'b0;
        data_write = 1'b0;
        mem_waitrequest = 1'b0;
        instr_address = RESET_VECTOR;
        data_address = 32'h0;
        data_writedata = 32'h0;
        mem_readdata = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    // Runs one instruction starting in a FETCH cycle; data accesses see data_waits stall cycles.
    task automatic run_instr(input int data_waits, input logic [31:0] iw, input logic [31:0] lw,
                             output int ce_cycle, output int reads);
        int stall;
        stall = 0;
        ce_cycle = 0;
        reads = 0;
        for (int c = 1; c <= 40; c++) begin
            mem_readdata = (c == 1) ? iw : lw;
            mem_waitrequest = (c > 1) && (mem_read || mem_write) && (stall < data_waits);
            if (mem_waitrequest) stall++;
            #1;
            if (mem_read && !mem_waitrequest) reads++;
            if (clk_enable && ce_cycle == 0) ce_cycle = c;
            tick();
            if (ce_cycle != 0) break;
        end
        mem_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        tests++;
        if ({clk_enable, bus_error, mem_read, mem_write, mem_byteenable} !== 8'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got %h expected 00", {clk_enable, bus_error, mem_read, mem_write, mem_byteenable});
        end
        tests++;
        if ({instr_readdata, data_readdata, mem_address, mem_writedata} !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", {instr_readdata, data_readdata, mem_address, mem_writedata});
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        int ce, rd;
        do_reset();
        active = 1'b1;
        tick();
        tests++;
        if ({mem_read, mem_write, mem_byteenable, mem_address} !== {1'b1, 1'b0, 4'hF, 32'hBFC00000}) begin
            fails++;
            $display("FAIL fetch_req: got %b %b %h %h expected 1 0 f bfc00000", mem_read, mem_write, mem_byteenable, mem_address);
        end
        run_instr(0, 32'h2402000A, 32'h0, ce, rd);
        tests++;
        if (ce !== 3) begin
            fails++;
            $display("FAIL fetch_latency: got %0d expected 3", ce);
        end
        tests++;
        if (rd !== 1) begin
            fails++;
            $display("FAIL fetch_reads: got %0d expected 1", rd);
        end
        tests++;
        if (instr_readdata !== 32'h2402000A) begin
            fails++;
            $display("FAIL fetch_data: got %h expected 2402000a", instr_readdata);
        end
    endtask

    task automatic test_load();
        int ce, rd;
        data_read = 1'b1;
        data_address = 32'h00000010;
        run_instr(2, 32'h8C020010, 32'hF0000000, ce, rd);
        data_read = 1'b0;
        tests++;
        if (ce !== 5) begin
            fails++;
            $display("FAIL load_latency: got %0d expected 5", ce);
        end
        tests++;
        if (data_readdata !== 32'hF0000000) begin
            fails++;
            $display("FAIL load_data: got %h expected f0000000", data_readdata);
        end
        tests++;
        if (rd !== 2) begin
            fails++;
            $display("FAIL load_reads: got %0d expected 2", rd);
        end
    endtask

    task automatic test_store();
        data_write = 1'b1;
        data_address = 32'h00000020;
        data_writedata = 32'h00000014;
        tick();
        mem_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_waitrequest = 1'b0;
            #1;
            tests++;
            if ({mem_write, mem_read, mem_byteenable, mem_writedata, mem_address, clk_enable} !==
                {1'b1, 1'b0, 4'hF, 32'h00000014, 32'h00000020, 1'b0}) begin
                fails++;
                $display("FAIL store_hold%0d: got w%b r%b be%h wd%h a%h ce%b expected w1 r0 bef wd00000014 a00000020 ce0",
                         k, mem_write, mem_read, mem_byteenable, mem_writedata, mem_address, clk_enable);
            end
            tick();
        end
        active = 1'b0;
        tests++;
        if ({clk_enable, mem_write} !== 2'b10) begin
            fails++;
            $display("FAIL store_commit: got ce%b w%b expected ce1 w0", clk_enable, mem_write);
        end
        data_write = 1'b0;
        tick();
        active = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if ({mem_read, mem_write, clk_enable} !== 3'b000) begin
                fails++;
                $display("FAIL halt%0d: got %b expected 000", k, {mem_read, mem_write, clk_enable});
            end
        end
    endtask

    task automatic test_back_to_back();
        int ce, rd, exp_rd;
`ifdef MEM_ARB_FETCH_BUF_EN
        exp_rd = 0;
`else
        exp_rd = 1;
`endif
        do_reset();
        instr_address = 32'h00400000;
        active = 1'b1;
        tick();
        run_instr(0, 32'h11111111, 32'h0, ce, rd);
        run_instr(0, 32'h22222222, 32'h0, ce, rd);
        tests++;
        if ({ce, rd} !== {32'd3, exp_rd}) begin
            fails++;
            $display("FAIL refetch: got ce %0d reads %0d expected ce 3 reads %0d", ce, rd, exp_rd);
        end
        tests++;
        if (instr_readdata !== 32'h11111111 && exp_rd == 0 || instr_readdata !== 32'h22222222 && exp_rd == 1) begin
            fails++;
            $display("FAIL refetch_data: got %h expected %h", instr_readdata, exp_rd == 0 ? 32'h11111111 : 32'h22222222);
        end
        data_write = 1'b1;
        data_address = 32'h00400000;
        run_instr(0, 32'h33333333, 32'h0, ce, rd);
        data_write = 1'b0;
        run_instr(0, 32'h44444444, 32'h0, ce, rd);
        tests++;
        if ({ce, rd, instr_readdata} !== {32'd3, 32'd1, 32'h44444444}) begin
            fails++;
            $display("FAIL store_invalidate: got ce %0d reads %0d instr %h expected ce 3 reads 1 instr 44444444", ce, rd, instr_readdata);
        end
    endtask

    task automatic test_errors();
        int ce, rd;
        for (int m = 0; m < 3; m++) begin
            do_reset();
            tests++;
            if (bus_error !== 1'b0) begin
                fails++;
                $display("FAIL err%0d_clear: got %b expected 0", m, bus_error);
            end
            active = 1'b1;
            data_read = 1'b1;
            data_write = (m == 0);
            data_address = (m == 1) ? 32'h00000002 : 32'h00000010;
            instr_address = (m == 2) ? 32'hBFC00001 : RESET_VECTOR;
            tick();
            run_instr(0, 32'h0, 32'h0, ce, rd);
            tests++;
            if ({ce, bus_error, clk_enable, mem_read, mem_write} !== {32'd0, 4'b1000}) begin
                fails++;
                $display("FAIL err%0d: got ce %0d be %b cke %b r %b w %b expected ce 0 be 1 cke 0 r 0 w 0",
                         m, ce, bus_error, clk_enable, mem_read, mem_write);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        active = 1'b1;
        mem_waitrequest = 1'b1;
        mem_readdata = 32'h00001234;
        tick();
        repeat (14) tick();
        mem_waitrequest = 1'b0;
        tick();
        tests++;
        if ({bus_error, instr_readdata} !== {1'b0, 32'h00001234}) begin
            fails++;
            $display("FAIL wait14: got err %b instr %h expected err 0 instr 00001234", bus_error, instr_readdata);
        end
        do_reset();
        active = 1'b1;
        mem_waitrequest = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) begin
            tests++;
            if ({mem_read, bus_error} !== 2'b10) begin
                fails++;
                $display("FAIL wait_cycle%0d: got r %b err %b expected r 1 err 0", k, mem_read, bus_error);
            end
            tick();
        end
        tests++;
        if ({bus_error, mem_read, clk_enable} !== 3'b100) begin
            fails++;
            $display("FAIL timeout: got %b expected 100", {bus_error, mem_read, clk_enable});
        end
        reset = 1'b1;
        #1;
        tests++;
        if (bus_error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_reset: got %b expected 0", bus_error);
        end
        tick();
        reset = 1'b0;
        mem_waitrequest = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        active = 1'b1;
        data_write = 1'b1;
        data_address = 32'h00000020;
        data_writedata = 32'hCAFEF00D;
        mem_readdata = 32'hDEADBEEF;
        tick();
        tick();
        mem_waitrequest = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({mem_write, mem_read, mem_address, mem_writedata, instr_readdata} !== 98'h0) begin
            fails++;
            $display("FAIL mid_reset: got w %b r %b a %h wd %h instr %h expected all 0",
                     mem_write, mem_read, mem_address, mem_writedata, instr_readdata);
        end
        tick();
        reset = 1'b0;
        active = 1'b0;
        tick();
        tests++;
        if ({mem_read, mem_write, clk_enable} !== 3'b000) begin
            fails++;
            $display("FAIL idle_hold: got %b expected 000", {mem_read, mem_write, clk_enable});
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_back_to_back();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
